// File: rtl/psum_accum_pkg.sv
// -----------------------------------------------------------------------------
// psum_accum_pkg
// Shared definitions for the partial-sum accumulator:
//   - FSM state encoding (IDLE / ACCUM / FINISH)
//   - guard-bit width used by the saturating adders
// No ports; imported by psum_accum.
// -----------------------------------------------------------------------------
package psum_accum_pkg;

    // FSM state encoding
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccum  = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    // Extra MSBs carried by each adder so signed overflow can be detected.
    localparam int unsigned SatGuardBits = 1;

endpackage

// File: rtl/psum_ram.sv
// -----------------------------------------------------------------------------
// psum_ram
// Simple dual-port RAM holding one partial sum per output pixel.
// One write port, one read port, 1-cycle synchronous read. A read of an
// address written on the same edge returns the old contents; the caller
// handles forwarding.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable
//   i_raddr  read address
//   o_rdata  read data, valid the cycle after i_re
// -----------------------------------------------------------------------------
module psum_ram #(
    parameter int unsigned Depth     = 4096,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 12
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [AddrWidth-1:0] i_waddr,
    input  logic [DataWidth-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [AddrWidth-1:0] i_raddr,
    output logic [DataWidth-1:0] o_rdata
);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [DataWidth-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/psum_accum.sv
// -----------------------------------------------------------------------------
// psum_accum
// Accumulates partial convolution sums over several 4-channel input passes.
// Pass 0 stores psums into the buffer, middle passes add into it, and the
// final pass adds the buffered value, the psum and the bias, optionally
// applies ReLU, and emits the result. All additions saturate.
// Two-stage pipeline: stage 1 registers the psum/address and reads the
// buffer; stage 2 adds and either writes back or outputs.
// Requires 2^AddrWidth >= MaxPixels.
// Ports:
//   i_clk           clock (rising edge)
//   i_rst           synchronous active-high reset
//   i_start         job start pulse; latches pix_num/pass_total/bias/relu
//   i_pix_num       output pixels per pass (1..MaxPixels)
//   i_pass_total    passes per job (1..2^PassWidth-1)
//   i_bias_in       bias added on the final pass
//   i_relu_en       clamp negative final results to 0
//   i_psum_in       incoming partial sum
//   i_psum_valid    i_psum_in valid
//   o_result_out    final accumulated pixel
//   o_result_valid  o_result_out valid
//   o_busy          job in progress
//   o_done          one-cycle pulse after the last result
// -----------------------------------------------------------------------------
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxPixels = 4096,
    parameter int unsigned AddrWidth = 12,
    parameter int unsigned PassWidth = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [AddrWidth-1:0] i_pix_num,
    input  logic [PassWidth-1:0] i_pass_total,
    input  logic [DataWidth-1:0] i_bias_in,
    input  logic                 i_relu_en,
    input  logic [DataWidth-1:0] i_psum_in,
    input  logic                 i_psum_valid,
    output logic [DataWidth-1:0] o_result_out,
    output logic                 o_result_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned SumWidth = DataWidth + SatGuardBits;

    // Signed add clamped to the DataWidth range.
    function automatic logic [DataWidth-1:0] sat_add(input logic [DataWidth-1:0] a,
                                                      input logic [DataWidth-1:0] b);
        logic [SumWidth-1:0] s;
        s = {{SatGuardBits{a[DataWidth-1]}}, a} + {{SatGuardBits{b[DataWidth-1]}}, b};
        // Overflow iff the guard bit disagrees with the result sign bit.
        if (s[SumWidth-1] != s[DataWidth-1]) begin
            sat_add = s[SumWidth-1] ? {1'b1, {(DataWidth-1){1'b0}}}
                                    : {1'b0, {(DataWidth-1){1'b1}}};
        end else begin
            sat_add = s[DataWidth-1:0];
        end
    endfunction

    // Control and job configuration
    logic [1:0]           r_state;
    logic [AddrWidth-1:0] r_pix_num;
    logic [PassWidth-1:0] r_pass_total;
    logic [DataWidth-1:0] r_bias;
    logic                 r_relu;
    logic [AddrWidth-1:0] r_pix_cnt;
    logic [PassWidth-1:0] r_pass_cnt;
    logic                 r_done;

    // Stage 1
    logic                 r_s1_valid;
    logic [DataWidth-1:0] r_s1_psum;
    logic [AddrWidth-1:0] r_s1_addr;
    logic                 r_s1_first;
    logic                 r_s1_last;

    // Read-during-write bypass
    logic                 r_fwd_hit;
    logic [DataWidth-1:0] r_fwd_data;

    // Stage 2 output
    logic [DataWidth-1:0] r_result;
    logic                 r_result_valid;

    logic                 w_accept;
    logic                 w_last_pix;
    logic                 w_first_pass;
    logic                 w_last_pass;
    logic [DataWidth-1:0] w_rd_data;
    logic [DataWidth-1:0] w_base;
    logic [DataWidth-1:0] w_acc;
    logic [DataWidth-1:0] w_biased;
    logic [DataWidth-1:0] w_final;
    logic                 w_wr_en;

    assign w_accept     = (r_state == StAccum) && i_psum_valid;
    // pix_num of 0 encodes MaxPixels when MaxPixels == 2^AddrWidth; the
    // wrapping subtract makes that case fall out naturally.
    assign w_last_pix   = (r_pix_cnt == (r_pix_num - AddrWidth'(1)));
    assign w_first_pass = (r_pass_cnt == '0);
    assign w_last_pass  = (r_pass_cnt == (r_pass_total - PassWidth'(1)));

    // Stage 2 datapath. Pass 0 never uses the buffer, so stale contents left
    // by an aborted job are harmless.
    always_comb begin
        w_base = '0;
        if (!r_s1_first) begin
            w_base = r_fwd_hit ? r_fwd_data : w_rd_data;
        end
        w_acc    = sat_add(w_base, r_s1_psum);
        w_biased = sat_add(w_acc, r_bias);
        w_final  = (r_relu && w_biased[DataWidth-1]) ? '0 : w_biased;
    end

    assign w_wr_en = r_s1_valid && !r_s1_last;

    psum_ram #(
        .Depth     (MaxPixels),
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_en),
        .i_waddr (r_s1_addr),
        .i_wdata (w_acc),
        .i_re    (w_accept),
        .i_raddr (r_pix_cnt),
        .o_rdata (w_rd_data)
    );

    // FSM and counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pix_num    <= '0;
            r_pass_total <= '0;
            r_bias       <= '0;
            r_relu       <= 1'b0;
            r_pix_cnt    <= '0;
            r_pass_cnt   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_pix_num    <= i_pix_num;
                        r_pass_total <= i_pass_total;
                        r_bias       <= i_bias_in;
                        r_relu       <= i_relu_en;
                        r_pix_cnt    <= '0;
                        r_pass_cnt   <= '0;
                        r_state      <= StAccum;
                    end
                end
                StAccum: begin
                    if (i_psum_valid) begin
                        if (w_last_pix) begin
                            r_pix_cnt  <= '0;
                            r_pass_cnt <= r_pass_cnt + PassWidth'(1);
                            if (w_last_pass) begin
                                r_state <= StFinish;
                            end
                        end else begin
                            r_pix_cnt <= r_pix_cnt + AddrWidth'(1);
                        end
                    end
                end
                StFinish: begin
                    // Last psum has left stage 1; its result is on the output now.
                    if (!r_s1_valid) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Pipeline registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_psum      <= '0;
            r_s1_addr      <= '0;
            r_s1_first     <= 1'b0;
            r_s1_last      <= 1'b0;
            r_fwd_hit      <= 1'b0;
            r_fwd_data     <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_psum  <= i_psum_in;
                r_s1_addr  <= r_pix_cnt;
                r_s1_first <= w_first_pass;
                r_s1_last  <= w_last_pass;
            end
            // The RAM returns old data when read and write hit the same
            // address on one edge; capture the write value instead.
            r_fwd_hit      <= w_accept && w_wr_en && (r_s1_addr == r_pix_cnt);
            r_fwd_data     <= w_acc;
            r_result_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid && r_s1_last) begin
                r_result <= w_final;
            end
        end
    end

    assign o_result_out   = r_result;
    assign o_result_valid = r_result_valid;
    assign o_busy         = (r_state != StIdle);
    assign o_done         = r_done;

endmodule
